bp_ball_engine: RTL and testbench



---
 rtl/bp_ball_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_bp_ball_engine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_ball_engine.sv
// Pong game-logic stage: advances the ball once per game tick, bounces it off
// the walls and paddles, detects goals, and sequences serve/play/game-over.
module bp_ball_engine #(
  parameter int unsigned FIELD_W     = 320,
  parameter int unsigned FIELD_H     = 240,
  parameter int unsigned FIELD_THICK = 4,
  parameter int unsigned PADDLE_W    = 4,
  parameter int unsigned PADDLE_H    = 32,
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned MAX_SCORE   = 10,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] ball_speed,
  input  logic [9:0] p1_paddle_x,
  input  logic [8:0] p1_paddle_y,
  input  logic [9:0] p2_paddle_x,
  input  logic [8:0] p2_paddle_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       hit,
  output logic       wall,
  output logic       scored,
  output logic       game_over
);

  localparam int unsigned CX    = (FIELD_W - BALL_SIZE) / 2;
  localparam int unsigned CY    = (FIELD_H - BALL_SIZE) / 2;
  localparam int unsigned YMIN  = FIELD_THICK;
  localparam int unsigned YMAX  = FIELD_H - FIELD_THICK - BALL_SIZE - 1;
  localparam int unsigned XMAX  = FIELD_W - BALL_SIZE;
  localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);

  // Signed 11-bit copies of the geometry so all motion math stays signed.
  localparam logic signed [10:0] YMIN_S = 11'(YMIN);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);
  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] PW_S   = 11'(PADDLE_W);
  localparam logic signed [10:0] PH_S   = 11'(PADDLE_H);
  localparam logic signed [10:0] BS_S   = 11'(BALL_SIZE);
  localparam logic signed [10:0] HALF_S = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] ZQ_S   = 11'(PADDLE_H / 4);
  localparam logic signed [10:0] ZERO_S = 11'd0;

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic              vx_neg_q, vx_neg_d;
  logic signed [2:0] vy_q, vy_d;
  logic [3:0]        spd_q, spd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        p1_q, p1_d, p2_q, p2_d;
  logic              hit_q, hit_d, wall_q, wall_d, scored_q, scored_d, over_q, over_d;

  // Motion results for one play tick.
  logic signed [10:0] y_s, x_s, spd_s, vy_s, ny, nx;
  logic signed [10:0] p1y_s, p2y_s, face1, face2, off1, off2;
  logic               ov1, ov2;
  logic [9:0]         mv_x;
  logic [8:0]         mv_y;
  logic               mv_vx_neg, mv_hit, mv_wall, goal_p1, goal_p2;
  logic signed [2:0]  vy_base, mv_vy;

  // Vertical speed chosen by where the ball struck the paddle face.
  function automatic logic signed [2:0] zone_vy(input logic signed [10:0] off);
    if (off < ZQ_S)               return -3'sd2;
    else if (off < 11'(2 * ZQ_S)) return -3'sd1;
    else if (off < 11'(3 * ZQ_S)) return 3'sd1;
    else                          return 3'sd2;
  endfunction

  function automatic logic signed [2:0] abs3(input logic signed [2:0] v);
    return v[2] ? 3'(-v) : v;
  endfunction

  // Candidate ball motion: paddle contact, goal detection and wall clamp.
  always_comb begin
    y_s       = $signed({2'b00, y_q});
    x_s       = $signed({1'b0, x_q});
    spd_s     = $signed({7'd0, spd_q});
    vy_s      = {{8{vy_q[2]}}, vy_q};
    ny        = y_s + vy_s;
    nx        = vx_neg_q ? (x_s - spd_s) : (x_s + spd_s);
    p1y_s     = $signed({2'b00, p1_paddle_y});
    p2y_s     = $signed({2'b00, p2_paddle_y});
    face1     = $signed({1'b0, p1_paddle_x}) + PW_S;
    face2     = $signed({1'b0, p2_paddle_x}) - BS_S;
    ov1       = ((y_s + BS_S) > p1y_s) && (y_s < (p1y_s + PH_S));
    ov2       = ((y_s + BS_S) > p2y_s) && (y_s < (p2y_s + PH_S));
    off1      = y_s + HALF_S - p1y_s;
    off2      = y_s + HALF_S - p2y_s;
    mv_x      = x_q;
    mv_vx_neg = vx_neg_q;
    mv_hit    = 1'b0;
    goal_p1   = 1'b0;
    goal_p2   = 1'b0;
    vy_base   = vy_q;
    if (vx_neg_q) begin
      if ((nx <= face1) && ov1) begin
        mv_x      = face1[9:0];
        mv_vx_neg = 1'b0;
        mv_hit    = 1'b1;
        vy_base   = zone_vy(off1);
      end else if (nx <= ZERO_S) begin
        goal_p2 = 1'b1;
      end else begin
        mv_x = nx[9:0];
      end
    end else begin
      if ((nx >= face2) && ov2) begin
        mv_x      = face2[9:0];
        mv_vx_neg = 1'b1;
        mv_hit    = 1'b1;
        vy_base   = zone_vy(off2);
      end else if (nx >= XMAX_S) begin
        goal_p1 = 1'b1;
      end else begin
        mv_x = nx[9:0];
      end
    end
    mv_wall = 1'b0;
    mv_y    = ny[8:0];
    mv_vy   = vy_base;
    if (ny <= YMIN_S) begin
      mv_y    = 9'(YMIN);
      mv_vy   = abs3(vy_base);
      mv_wall = 1'b1;
    end else if (ny >= YMAX_S) begin
      mv_y    = 9'(YMAX);
      mv_vy   = 3'(-abs3(vy_base));
      mv_wall = 1'b1;
    end
  end

  // Next-state and output logic; start overrides everything, else act on tick.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_neg_d = vx_neg_q;
    vy_d     = vy_q;
    spd_d    = spd_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    hit_d    = 1'b0;
    wall_d   = 1'b0;
    scored_d = 1'b0;
    if (start) begin
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      x_d      = 10'(CX);
      y_d      = 9'(CY);
      vx_neg_d = 1'b0;
      vy_d     = 3'sd1;
      cnt_d    = '0;
      state_d  = S_SERVE;
    end else if (tick) begin
      case (state_q)
        S_SERVE: begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            cnt_d   = '0;
            spd_d   = (ball_speed == 4'd0) ? 4'd2 : ball_speed;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PLAY: begin
          x_d      = mv_x;
          y_d      = mv_y;
          vx_neg_d = mv_vx_neg;
          vy_d     = mv_vy;
          hit_d    = mv_hit;
          wall_d   = mv_wall;
          if (goal_p1 || goal_p2) begin
            scored_d = 1'b1;
            x_d      = 10'(CX);
            y_d      = 9'(CY);
            vy_d     = 3'sd1;
            vx_neg_d = goal_p2;
            cnt_d    = '0;
            if (goal_p1) begin
              p1_d    = (p1_q == 4'(MAX_SCORE)) ? p1_q : p1_q + 4'd1;
              state_d = (p1_d == 4'(MAX_SCORE)) ? S_OVER : S_SERVE;
            end else begin
              p2_d    = (p2_q == 4'(MAX_SCORE)) ? p2_q : p2_q + 4'd1;
              state_d = (p2_d == 4'(MAX_SCORE)) ? S_OVER : S_SERVE;
            end
          end
        end
        default: ;
      endcase
    end
    over_d = (state_d == S_OVER);
  end

  // State and output registers with asynchronous reset to the idle centre.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= 10'(CX);
      y_q      <= 9'(CY);
      vx_neg_q <= 1'b0;
      vy_q     <= 3'sd1;
      spd_q    <= 4'd2;
      cnt_q    <= '0;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      hit_q    <= 1'b0;
      wall_q   <= 1'b0;
      scored_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_neg_q <= vx_neg_d;
      vy_q     <= vy_d;
      spd_q    <= spd_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      hit_q    <= hit_d;
      wall_q   <= wall_d;
      scored_q <= scored_d;
      over_q   <= over_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign hit       = hit_q;
  assign wall      = wall_q;
  assign scored    = scored_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_bp_ball_engine.sv
// Self-checking bench for bp_ball_engine: a cycle model feeds a scoreboard
// queue that is compared every clock, plus directed constant checks per scenario.
module tb_bp_ball_engine;

  logic       clock = 1'b0;
  logic       reset, tick, start;
  logic [3:0] ball_speed;
  logic [9:0] p1x, p2x;
  logic [8:0] p1y, p2y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] p1_score, p2_score;
  logic       hit, wall, scored, game_over;

  int errors = 0;
  int checks = 0;
  logic [30:0] exp_q[$];

  // Reference model state (0 idle, 1 serve, 2 play, 3 over).
  int m_state, m_x, m_y, m_vx, m_vy, m_s, m_cnt, m_p1, m_p2;
  bit m_hit, m_wall, m_sc;
  int m_hits, m_walls, d_hits, d_walls;
  int offs[4] = '{4, 12, 20, 30};

  bp_ball_engine dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start),
    .ball_speed(ball_speed),
    .p1_paddle_x(p1x), .p1_paddle_y(p1y),
    .p2_paddle_x(p2x), .p2_paddle_y(p2y),
    .ball_x(ball_x), .ball_y(ball_y),
    .p1_score(p1_score), .p2_score(p2_score),
    .hit(hit), .wall(wall), .scored(scored), .game_over(game_over)
  );

  always #5 clock = ~clock;

  function automatic int zone(input int off);
    if (off < 8) return -2;
    if (off < 16) return -1;
    if (off < 24) return 1;
    return 2;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [30:0] model_vec();
    return {10'(m_x), 9'(m_y), 4'(m_p1), 4'(m_p2), m_hit, m_wall, m_sc, (m_state == 3)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 158; m_y = 118; m_vx = 1; m_vy = 1; m_s = 2; m_cnt = 0;
    m_p1 = 0; m_p2 = 0; m_hit = 0; m_wall = 0; m_sc = 0;
  endtask

  task automatic model_step(input bit t, input bit st);
    int ny, nx, nvy, vyb, face, py, goal;
    bit hitf;
    m_hit = 0; m_wall = 0; m_sc = 0;
    if (st) begin
      m_p1 = 0; m_p2 = 0; m_x = 158; m_y = 118; m_vx = 1; m_vy = 1; m_cnt = 0; m_state = 1;
    end else if (t) begin
      if (m_state == 1) begin
        if (m_cnt == 59) begin
          m_cnt = 0; m_s = (ball_speed == 0) ? 2 : int'(ball_speed); m_state = 2;
        end else m_cnt++;
      end else if (m_state == 2) begin
        ny = m_y + m_vy;
        nx = (m_vx > 0) ? m_x + m_s : m_x - m_s;
        vyb = m_vy; goal = 0; hitf = 0;
        if (m_vx < 0) begin
          py = int'(p1y); face = int'(p1x) + 4;
          if (nx <= face && m_y + 4 > py && m_y < py + 32) begin
            nx = face; m_vx = 1; hitf = 1; vyb = zone(m_y + 2 - py);
          end else if (nx <= 0) goal = 2;
        end else begin
          py = int'(p2y); face = int'(p2x) - 4;
          if (nx >= face && m_y + 4 > py && m_y < py + 32) begin
            nx = face; m_vx = -1; hitf = 1; vyb = zone(m_y + 2 - py);
          end else if (nx >= 316) goal = 1;
        end
        if (ny <= 4) begin ny = 4; nvy = iabs(vyb); m_wall = 1; end
        else if (ny >= 231) begin ny = 231; nvy = -iabs(vyb); m_wall = 1; end
        else nvy = vyb;
        m_hit = hitf; m_x = nx; m_y = ny; m_vy = nvy;
        if (goal != 0) begin
          m_sc = 1; m_x = 158; m_y = 118; m_vy = 1; m_cnt = 0;
          if (goal == 1) begin
            if (m_p1 < 10) m_p1++;
            m_vx = 1; m_state = (m_p1 == 10) ? 3 : 1;
          end else begin
            if (m_p2 < 10) m_p2++;
            m_vx = -1; m_state = (m_p2 == 10) ? 3 : 1;
          end
        end
      end
    end
    m_hits += int'(m_hit); m_walls += int'(m_wall);
  endtask

  // Drive one clock of stimulus, queue the model's expectation, return after the edge.
  task automatic step(input bit t, input bit st);
    @(negedge clock);
    tick = t; start = st;
    model_step(t, st);
    exp_q.push_back(model_vec());
    @(posedge clock); #1;
    tick = 0; start = 0;
    d_hits += int'(hit); d_walls += int'(wall);
  endtask

  function automatic logic [8:0] track(input int tgt);
    int py;
    py = m_y + 2 - tgt;
    if (py < 0) py = 0;
    return 9'(py);
  endfunction

  function automatic logic [8:0] away();
    return (m_y > 120) ? 9'd0 : 9'd200;
  endfunction

  // Scoreboard: pop and compare one expectation per clock that had stimulus.
  initial begin
    logic [30:0] e, a;
    forever begin
      @(posedge clock); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ball_x, ball_y, p1_score, p2_score, hit, wall, scored, game_over};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL sb: got x=%0d y=%0d p1=%0d p2=%0d hwso=%b want x=%0d y=%0d p1=%0d p2=%0d hwso=%b",
                   a[30:21], a[20:12], a[11:8], a[7:4], a[3:0],
                   e[30:21], e[20:12], e[11:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1; tick = 0; start = 0; ball_speed = 0;
    p1x = 10'd4; p2x = 10'd312; p1y = 9'd100; p2y = 9'd100;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({ball_x, ball_y, p1_score, p2_score, hit, wall, scored, game_over} !==
        {10'd158, 9'd118, 4'd0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d p1=%0d p2=%0d over=%b want 158 118 0 0 0",
               ball_x, ball_y, p1_score, p2_score, game_over);
    end
    @(negedge clock); reset = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    checks++;
    if (ball_x !== 10'd158 || ball_y !== 9'd118) begin
      errors++;
      $display("FAIL idle_hold: got x=%0d y=%0d want 158 118", ball_x, ball_y);
    end
  endtask

  task automatic test_serve();
    int bad;
    ball_speed = 4'd0;
    bad = 0;
    step(0, 1);
    for (int i = 0; i < 60; i++) begin
      step(1, 0);
      if (ball_x !== 10'd158 || ball_y !== 9'd118) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL serve_hold: %0d ticks moved the ball, want 0", bad);
    end
    step(0, 0);
    step(1, 0);
    checks++;
    if (ball_x !== 10'd160 || ball_y !== 9'd119) begin
      errors++;
      $display("FAIL first_move: got x=%0d y=%0d want 160 119", ball_x, ball_y);
    end
  endtask

  task automatic test_rally(input int n);
    m_hits = 0; m_walls = 0; d_hits = 0; d_walls = 0;
    for (int i = 0; i < n; i++) begin
      p1y = track(offs[m_hits % 4]);
      p2y = track(offs[m_hits % 4]);
      step(1, 0);
      step(0, 0);
    end
    checks++;
    if (d_hits !== m_hits) begin
      errors++;
      $display("FAIL rally_hits: got %0d want %0d", d_hits, m_hits);
    end
    checks++;
    if (d_walls !== m_walls) begin
      errors++;
      $display("FAIL rally_walls: got %0d want %0d", d_walls, m_walls);
    end
  endtask

  task automatic test_goal_p2();
    int prev, n;
    prev = m_p2; n = 0;
    while (m_p2 == prev && n < 1000) begin
      p1y = (m_vx < 0) ? away() : track(12);
      p2y = track(20);
      step(1, 0);
      n++;
    end
    checks++;
    if (m_p2 == prev) begin
      errors++;
      $display("FAIL goal_timeout: no goal within %0d ticks", n);
    end
    checks++;
    if (p2_score !== 4'(prev + 1) || scored !== 1'b1 || ball_x !== 10'd158 || ball_y !== 9'd118) begin
      errors++;
      $display("FAIL goal_p2: got p2=%0d scored=%b x=%0d y=%0d want %0d 1 158 118",
               p2_score, scored, ball_x, ball_y, prev + 1);
    end
    step(0, 0);
    checks++;
    if (scored !== 1'b0) begin
      errors++;
      $display("FAIL scored_width: got %b want 0", scored);
    end
    ball_speed = 4'd5;
    for (int i = 0; i < 60; i++) step(1, 0);
    step(1, 0);
    checks++;
    if (ball_x !== 10'd153 || ball_y !== 9'd119) begin
      errors++;
      $display("FAIL serve_left: got x=%0d y=%0d want 153 119", ball_x, ball_y);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    @(negedge clock);
    reset = 1;
    model_reset();
    #1;
    checks++;
    if ({ball_x, ball_y, p1_score, p2_score, hit, wall, scored, game_over} !==
        {10'd158, 9'd118, 4'd0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d p1=%0d p2=%0d want 158 118 0 0",
               ball_x, ball_y, p1_score, p2_score);
    end
    @(posedge clock); #1;
    checks++;
    if (ball_x !== 10'd158 || ball_y !== 9'd118 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got x=%0d y=%0d over=%b want 158 118 0", ball_x, ball_y, game_over);
    end
    @(negedge clock); reset = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
  endtask

  task automatic test_game_over();
    int n, bad;
    ball_speed = 4'd2;
    step(0, 1);
    n = 0;
    while (m_state != 3 && n < 4000) begin
      p1y = away(); p2y = away();
      step(1, 0);
      n++;
    end
    checks++;
    if (m_state != 3) begin
      errors++;
      $display("FAIL over_timeout: game not over after %0d ticks", n);
    end
    checks++;
    if (p1_score !== 4'd10 || p2_score !== 4'd0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL game_over: got p1=%0d p2=%0d over=%b want 10 0 1", p1_score, p2_score, game_over);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      if ({ball_x, ball_y, p1_score, p2_score, hit, wall, scored, game_over} !==
          {10'd158, 9'd118, 4'd10, 4'd0, 4'b0001}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL over_frozen: %0d ticks changed outputs, want 0", bad);
    end
    step(1, 1);
    checks++;
    if (p1_score !== 4'd0 || p2_score !== 4'd0 || game_over !== 1'b0 ||
        ball_x !== 10'd158 || ball_y !== 9'd118) begin
      errors++;
      $display("FAIL restart: got p1=%0d p2=%0d over=%b x=%0d y=%0d want 0 0 0 158 118",
               p1_score, p2_score, game_over, ball_x, ball_y);
    end
    for (int i = 0; i < 60; i++) step(1, 0);
    step(1, 0);
    checks++;
    if (ball_x !== 10'd160 || ball_y !== 9'd119) begin
      errors++;
      $display("FAIL restart_serve: got x=%0d y=%0d want 160 119", ball_x, ball_y);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally(600);
    test_goal_p2();
    test_mid_reset();
    test_game_over();
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
